// File: rtl/yl3_display_sched.sv
// Display scheduler for the driver_yl3 8-digit serial display: arbitrates normal/alert messages and runs the load/ready handshake.
// Optional periodic re-send is compiled in with `define YL3_SCHED_REFRESH_EN.
module yl3_display_sched #(
    parameter int unsigned ALERT_CYCLES   = 50_000_000,
    parameter int unsigned REFRESH_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] norm_data,
    input  logic        norm_valid,
    input  logic [63:0] alrt_data,
    input  logic        alrt_valid,
    input  logic        drv_ready,
    output logic [63:0] drv_data,
    output logic        drv_load,
    output logic        busy,
    output logic        alert_active,
    output logic        xfer_done
);

    localparam logic [63:0] BLANK = 64'h2020_2020_2020_2020;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t      state;
    logic [63:0] norm_buf;
    logic [63:0] alrt_buf;
    logic        norm_pend;
    logic        alrt_pend;
    logic        src_alert;
    logic [31:0] alert_tmr;

    logic sel_alert;
    logic sel_pend;
    logic refresh_due;
    logic start;
    logic reload;
    logic expire;

    assign sel_alert = alert_active | alrt_pend;
    assign sel_pend  = sel_alert ? alrt_pend : norm_pend;
    assign start     = (state == S_IDLE) && drv_ready && (sel_pend || refresh_due);
    // Only a transfer carrying a freshly captured alert restarts the alert window.
    assign reload    = (state == S_LOAD) && !drv_ready && src_alert;
    assign expire    = alert_active && !reload && (alert_tmr <= 32'd1);
    assign busy      = (state != S_IDLE);

`ifdef YL3_SCHED_REFRESH_EN
    logic [31:0] refresh_cnt;

    assign refresh_due = (refresh_cnt == REFRESH_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= 32'd0;
        end else if (start) begin
            refresh_cnt <= 32'd0;
        end else if ((state == S_IDLE) && !refresh_due) begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end
`else
    assign refresh_due = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drv_data  <= BLANK;
            drv_load  <= 1'b0;
            xfer_done <= 1'b0;
            src_alert <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        drv_data  <= sel_alert ? alrt_buf : norm_buf;
                        drv_load  <= 1'b1;
                        src_alert <= sel_alert & alrt_pend;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!drv_ready) begin
                        drv_load <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (drv_ready) begin
                        xfer_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A capture in the same cycle as the snapshot keeps its pending flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_buf  <= BLANK;
            alrt_buf  <= BLANK;
            norm_pend <= 1'b1;
            alrt_pend <= 1'b0;
        end else begin
            if (norm_valid) begin
                norm_buf <= norm_data;
            end
            if (alrt_valid) begin
                alrt_buf <= alrt_data;
            end
            norm_pend <= norm_valid | expire | (norm_pend & ~(start & ~sel_alert));
            alrt_pend <= alrt_valid | (alrt_pend & ~(start & sel_alert));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alert_active <= 1'b0;
            alert_tmr    <= 32'd0;
        end else if (reload) begin
            alert_active <= 1'b1;
            alert_tmr    <= ALERT_CYCLES;
        end else if (alert_active) begin
            if (alert_tmr <= 32'd1) begin
                alert_active <= 1'b0;
                alert_tmr    <= 32'd0;
            end else begin
                alert_tmr <= alert_tmr - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_yl3_display_sched.sv
// Bench for yl3_display_sched: directed scenarios plus randomized traffic against a deadline-based behavioural model.
module tb_yl3_display_sched;

    localparam int          AC    = 100;
    localparam int          RC    = 50;
    localparam logic [63:0] BLANK = 64'h2020_2020_2020_2020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] norm_data = '0;
    logic        norm_valid = 1'b0;
    logic [63:0] alrt_data = '0;
    logic        alrt_valid = 1'b0;
    logic        drv_ready = 1'b1;
    logic [63:0] drv_data;
    logic        drv_load;
    logic        busy;
    logic        alert_active;
    logic        xfer_done;

    yl3_display_sched #(.ALERT_CYCLES(AC), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n),
        .norm_data(norm_data), .norm_valid(norm_valid),
        .alrt_data(alrt_data), .alrt_valid(alrt_valid),
        .drv_ready(drv_ready), .drv_data(drv_data), .drv_load(drv_load),
        .busy(busy), .alert_active(alert_active), .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: alert lifetime kept as an absolute deadline in clock edges.
    logic [63:0] m_nbuf, m_abuf, m_data;
    bit          m_npend, m_apend, m_load, m_done, m_src, m_active;
    int          m_phase;
    int          m_rcnt;
    longint      m_k, m_alert_end;

    always @(posedge clk or negedge rst_n) begin
        bit sel, pend, due, reload;
        if (!rst_n) begin
            m_nbuf = BLANK; m_abuf = BLANK; m_data = BLANK;
            m_npend = 1; m_apend = 0; m_load = 0; m_done = 0; m_src = 0;
            m_active = 0; m_phase = 0; m_rcnt = 0; m_k = 0; m_alert_end = 0;
        end else begin
            m_k++;
            m_done = 0;
            reload = 0;
            sel  = m_active || m_apend;
            pend = sel ? m_apend : m_npend;
            due  = 0;
`ifdef YL3_SCHED_REFRESH_EN
            due = (m_rcnt == RC);
`endif
            if (m_phase == 0) begin
                if (drv_ready && (pend || due)) begin
                    m_data  = sel ? m_abuf : m_nbuf;
                    m_src   = sel && m_apend;
                    if (sel) m_apend = 0; else m_npend = 0;
                    m_load  = 1;
                    m_phase = 1;
                    m_rcnt  = 0;
                end else if (!due) begin
                    m_rcnt++;
                end
            end else if (m_phase == 1) begin
                if (!drv_ready) begin
                    m_load  = 0;
                    m_phase = 2;
                    if (m_src) begin
                        m_alert_end = m_k + AC;
                        reload = 1;
                    end
                end
            end else if (drv_ready) begin
                m_done  = 1;
                m_phase = 0;
            end
            if (m_active && !reload && m_k == m_alert_end) m_npend = 1;
            if (norm_valid) begin m_nbuf = norm_data; m_npend = 1; end
            if (alrt_valid) begin m_abuf = alrt_data; m_apend = 1; end
            m_active = (m_k < m_alert_end);
        end
    end

    always @(negedge clk) begin
        chk("drv_data", drv_data, m_data);
        chk("drv_load", drv_load, m_load);
        chk("busy", busy, m_phase != 0);
        chk("alert_active", alert_active, m_active);
        chk("xfer_done", xfer_done, m_done);
    end

    // Driver stand-in: holds ready through >=2 load cycles, then drops it for a random busy time.
    int ld_cnt = 0;
    int bz = 0;
    bit drops_en = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            drv_ready = 1'b1; ld_cnt = 0; bz = 0;
        end else if (drv_ready) begin
            if (drv_load) begin
                ld_cnt++;
                if (ld_cnt >= 2 && (!drops_en || $urandom_range(0, 1) == 0)) begin
                    drv_ready = 1'b0; ld_cnt = 0; bz = $urandom_range(1, 5);
                end
            end else if (drops_en && $urandom_range(0, 15) == 0) begin
                drv_ready = 1'b0; bz = $urandom_range(1, 3);
            end
        end else begin
            bz--;
            if (bz <= 0) drv_ready = 1'b1;
        end
    end

    int          xfer_cnt = 0;
    int          load_len = 0, ld_run = 0;
    int          alert_len = 0, al_run = 0;
    logic        prev_load = 1'b0;
    logic [63:0] log_q[$];

    always @(negedge clk) begin
        if (xfer_done === 1'b1) xfer_cnt++;
        if (drv_load === 1'b1 && !prev_load) log_q.push_back(drv_data);
        if (drv_load === 1'b1) ld_run++;
        else if (ld_run > 0) begin load_len = ld_run; ld_run = 0; end
        if (alert_active === 1'b1) al_run++;
        else if (al_run > 0) begin alert_len = al_run; al_run = 0; end
        prev_load = (drv_load === 1'b1);
    end

    function automatic logic [63:0] log_at(input int n);
        return (n >= 0 && n < log_q.size()) ? log_q[n] : 64'hx;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_norm(input logic [63:0] d);
        norm_data = d; norm_valid = 1'b1;
        step();
        norm_valid = 1'b0;
    endtask

    task automatic send_alrt(input logic [63:0] d);
        alrt_data = d; alrt_valid = 1'b1;
        step();
        alrt_valid = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget, input string name);
        int i = 0;
        while (xfer_cnt < target && i < budget) begin step(); i++; end
        chk(name, xfer_cnt >= target, 1'b1);
    endtask

    localparam logic [63:0] HELLO  = "HELLO   ";
    localparam logic [63:0] ALARM  = "ALArm   ";
    localparam logic [63:0] ABCD   = "ABCDEFGH";
    localparam logic [63:0] WXYZ   = "WXYZwxyz";
    localparam logic [63:0] ALERT2 = "ALERT2  ";

    initial begin
        int base, i;
        logic [63:0] d;

        // Reset blanking
        repeat (3) step();
        chk("rst_drv_data", drv_data, BLANK);
        chk("rst_drv_load", drv_load, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alert_active", alert_active, 1'b0);
        chk("rst_xfer_done", xfer_done, 1'b0);
        rst_n = 1'b1;
        wait_xfers(1, 50, "blank_xfer_timeout");
        chk("blank_data", log_at(0), BLANK);
        repeat (10) step();
        chk("blank_single_xfer", xfer_cnt, 1);

        // Normal transfer
        send_norm(64'h3132_3334_3536_3738);
        wait_xfers(2, 50, "norm_xfer_timeout");
        chk("norm_data", log_at(1), 64'h3132_3334_3536_3738);
        chk("norm_load_len", load_len, 2);

        // Alert override and restore
        send_norm(HELLO);
        wait_xfers(3, 50, "hello_xfer_timeout");
        send_alrt(ALARM);
        wait_xfers(4, 50, "alarm_xfer_timeout");
        chk("alarm_data", log_at(3), ALARM);
        i = 0;
        while (alert_active === 1'b1 && i < 300) begin step(); i++; end
        chk("alert_fall_timeout", alert_active, 1'b0);
        chk("alert_len", alert_len, AC);
        wait_xfers(5, 50, "restore_xfer_timeout");
        chk("restore_data", log_at(4), HELLO);

        // Captures while the driver is busy
        send_norm(ABCD);
        i = 0;
        while (!(busy === 1'b1 && drv_load === 1'b0) && i < 50) begin step(); i++; end
        chk("wait_state_reached", busy === 1'b1 && drv_load === 1'b0, 1'b1);
        chk("mid_data_held", drv_data, ABCD);
        norm_data = WXYZ; norm_valid = 1'b1;
        alrt_data = ALERT2; alrt_valid = 1'b1;
        step();
        norm_valid = 1'b0; alrt_valid = 1'b0;
        wait_xfers(6, 50, "mid_xfer_timeout");
        chk("mid_first_data", log_at(5), ABCD);
        wait_xfers(7, 50, "mid_alert_timeout");
        chk("mid_alert_data", log_at(6), ALERT2);
        wait_xfers(8, 300, "mid_norm_timeout");
        chk("mid_norm_data", log_at(7), WXYZ);

        // Asynchronous reset during a load with the alert active
        send_alrt(ALARM);
        wait_xfers(9, 50, "pre_rst_alarm_timeout");
        send_alrt(ALERT2);
        i = 0;
        while (drv_load !== 1'b1 && i < 50) begin step(); i++; end
        chk("pre_rst_load_seen", drv_load, 1'b1);
        chk("pre_rst_alert_on", alert_active, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_drv_load", drv_load, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_alert_active", alert_active, 1'b0);
        chk("async_rst_drv_data", drv_data, BLANK);
        repeat (2) step();
        base = xfer_cnt;
        rst_n = 1'b1;
        wait_xfers(base + 1, 50, "post_rst_blank_timeout");
        chk("post_rst_blank", log_at(log_q.size() - 1), BLANK);

        // Randomized traffic with driver stalls
        drops_en = 1;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'($urandom_range(32, 126));
            norm_data  = d;
            norm_valid = ($urandom_range(0, 39) == 0);
            for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'($urandom_range(32, 126));
            alrt_data  = d;
            alrt_valid = ($urandom_range(0, 299) == 0);
            step();
        end
        norm_valid = 1'b0; alrt_valid = 1'b0; drops_en = 0;

        // Idle behaviour with nothing pending
        repeat (400) step();
        base = xfer_cnt;
        repeat (300) step();
`ifdef YL3_SCHED_REFRESH_EN
        chk("refresh_resends", (xfer_cnt - base) >= 4, 1'b1);
`else
        chk("no_refresh_resend", xfer_cnt - base, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
